// File: rtl/seq_signed_divider_if.sv
// Start/ready handshake bundle shared by the sequential divider and its drivers.
interface seq_signed_divider_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             ready;
    logic             busy;
    logic             div_by_zero;

    // Requester side: issues operands, observes results.
    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, ready, busy, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, ready, busy, div_by_zero
    );
endinterface

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: restoring shift-subtract on magnitudes, one
// quotient bit per clock, then sign correction (truncating / and % semantics).
module seq_signed_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    seq_signed_divider_if.slave   bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dsr;
    logic [CW-1:0]    r_cnt;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_dbz;

    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_ready;
    logic             r_busy;
    logic             r_div_by_zero;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dsr_mag;
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_keep;
    logic             w_last;
    logic [WIDTH-1:0] w_q_fin;
    logic [WIDTH-1:0] w_r_fin;

    // Operand magnitudes; the most negative value maps onto its unsigned magnitude.
    assign w_dvd_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
    assign w_dsr_mag = bus.divisor[WIDTH-1]  ? (~bus.divisor  + WIDTH'(1)) : bus.divisor;

    // One restoring step: shift {rem, dvd} left, trial-subtract the divisor.
    assign w_shift = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial = w_shift - {2'b00, r_dsr};
    assign w_keep  = ~w_trial[WIDTH+1];
    assign w_last  = (r_cnt == CW'(WIDTH));

    // Sign correction. With a zero divisor every trial keeps, so the partial
    // remainder ends as |dividend| and the signed remainder is the dividend.
    assign w_q_fin = r_dbz   ? {WIDTH{1'b1}}
                   : r_q_neg ? (~r_dvd + WIDTH'(1)) : r_dvd;
    assign w_r_fin = r_r_neg ? (~r_rem[WIDTH-1:0] + WIDTH'(1)) : r_rem[WIDTH-1:0];

    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.ready       = r_ready;
    assign bus.busy        = r_busy;
    assign bus.div_by_zero = r_div_by_zero;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: IDLE -> CALC on start, CALC for WIDTH steps + writeback, DONE one cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_next = ST_CALC;
            ST_CALC: if (w_last)    w_next = ST_DONE;
            ST_DONE:                w_next = ST_IDLE;
            default:                w_next = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem         <= '0;
            r_dvd         <= '0;
            r_dsr         <= '0;
            r_cnt         <= '0;
            r_q_neg       <= 1'b0;
            r_r_neg       <= 1'b0;
            r_dbz         <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_ready       <= 1'b0;
            r_busy        <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_ready <= (w_next == ST_DONE);
            r_busy  <= (w_next != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_dvd   <= w_dvd_mag;
                        r_dsr   <= w_dsr_mag;
                        r_q_neg <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        r_r_neg <= bus.dividend[WIDTH-1];
                        r_dbz   <= (bus.divisor == '0);
                        r_rem   <= '0;
                        r_cnt   <= '0;
                    end
                end
                ST_CALC: begin
                    if (!w_last) begin
                        r_rem <= w_keep ? w_trial[WIDTH:0] : w_shift[WIDTH:0];
                        r_dvd <= {r_dvd[WIDTH-2:0], w_keep};
                        r_cnt <= r_cnt + CW'(1);
                    end else begin
                        r_quotient    <= w_q_fin;
                        r_remainder   <= w_r_fin;
                        r_div_by_zero <= r_dbz;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/seq_signed_divider.md
# seq_signed_divider

Multi-cycle signed integer divider, the inverse-operation companion to the team's sequential array multiplier. It uses the same start/ready handshake, so one bench harness and one datapath controller can drive either unit. It runs a restoring shift-subtract algorithm on operand magnitudes, one quotient bit per clock, then sign-corrects the result. It returns SystemVerilog `/` and `%` semantics: quotient truncates toward zero, and the remainder takes the dividend's sign.

## Interface
- `WIDTH`, 16: operand, quotient and remainder width in bits; legal range 4..64.
- `clk`  input  1: single clock; all state changes on the rising edge.
- `reset`  input  1: asynchronous, active-high reset; forces IDLE and clears all outputs.
- `start`  input  1: request; sampled only in IDLE.
- `dividend`  input  WIDTH: signed dividend; sampled on the accepting edge only.
- `divisor`  input  WIDTH: signed divisor; sampled on the accepting edge only.
- `quotient`  output  WIDTH: signed quotient; held from DONE until the next accepted start.
- `remainder`  output  WIDTH: signed remainder; held likewise.
- `ready`  output  1: one-cycle pulse marking valid results.
- `busy`  output  1: high in CALC and DONE.
- `div_by_zero`  output  1: set with results when divisor was 0; held likewise.

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE to CALC on `start`=1.
  - Latch the dividend and divisor magnitudes as WIDTH-bit unsigned values. |−2^(WIDTH−1)| fits unsigned.
  - Latch the sign flags `q_neg` = sign(dividend) XOR sign(divisor) and `r_neg` = sign(dividend).
  - Latch a zero-divisor flag.
  - Clear the partial remainder (WIDTH+1 bits) and the iteration counter.
- CALC runs exactly WIDTH iterations, one per edge:
  - Shift {partial remainder, dividend register} left by 1.
  - Trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - After iteration WIDTH, go to DONE.
- DONE lasts one cycle, then returns to IDLE. On entry to DONE, register the outputs:
  - Normal case: `quotient` = `q_neg` ? −Q : Q and `remainder` = `r_neg` ? −R : R, both truncated to WIDTH bits.
  - Divisor = 0: `quotient` = all ones (−1), `remainder` = original dividend, `div_by_zero` = 1. The iterations still run, so latency stays fixed.
  - Overflow (−2^(WIDTH−1) / −1): `quotient` = −2^(WIDTH−1) (two's-complement wrap), `remainder` = 0, `div_by_zero` = 0.
- For every divisor ≠ 0, `quotient`·`divisor` + `remainder` == `dividend` in WIDTH-bit arithmetic, and |`remainder`| < |`divisor`|.
- `start` while `busy` is ignored: no restart, no queuing, operands not resampled.
- `start` in the DONE cycle is also ignored. The earliest accepted start is the edge after DONE, in IDLE.

## Timing
- Reset values: `quotient`=0, `remainder`=0, `ready`=0, `busy`=0, `div_by_zero`=0.
- Let E0 be the edge that samples `start`=1 in IDLE.
  - Edges E1..E(WIDTH) perform the iterations.
  - Edge E(WIDTH+1) registers the results and sets `ready`=1, entering DONE.
  - Edge E(WIDTH+2) clears `ready` and enters IDLE.
- Latency from accepting edge to `ready` high is WIDTH+1 edges: 17 for WIDTH=16.
- `ready` is high for exactly one cycle, so the bench can wait for it to rise and then fall.
- Back-to-back throughput is one division per WIDTH+3 cycles.
- `busy` rises after E0 and falls after E(WIDTH+2).
- Previous results stay visible from the end of DONE until DONE of the next operation.
- Reset asserted mid-CALC or in DONE takes effect immediately, without waiting for a clock edge. The operation is abandoned: no `ready` pulse, outputs cleared.
- After reset deasserts, the first `start` is accepted on the next rising edge.

## Test plan
- WIDTH=16. 100/7 → `quotient`=14, `remainder`=2, `ready` one cycle exactly 17 edges after the accepting edge, `div_by_zero`=0. Then −100/7 → −14 r −2; 100/−7 → −14 r 2; −100/−7 → 14 r −2.
- Edge operands:
  - −32768/−1 → −32768 r 0.
  - −32768/1 → −32768 r 0.
  - 32767/−32768 → 0 r 32767.
  - 0/5 → 0 r 0.
- 1234/0 → `quotient`=−1, `remainder`=1234, `div_by_zero`=1, same 17-edge latency. The next valid division clears `div_by_zero`.
- Busy-start rejection: start 1000/3, then pulse `start` with 7/7 on edge E5 and again in the DONE cycle.
  - Required: single `ready` pulse with 333 r 1.
  - No second pulse until a fresh start is issued in IDLE.
- Async reset: assert `reset` between edges E8 and E9 of an operation.
  - Required: outputs and `busy` drop to 0 immediately, with no `ready` pulse.
  - After release, −7/2 → −3 r −1.
- Random regression: 1000 random signed pairs with divisor ≠ 0.
  - Check `quotient` == `dividend`/`divisor` and `remainder` == `dividend`%`divisor` (SystemVerilog semantics, overflow case excepted).
  - Check that `ready` rises and falls once per operation.
